// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave receive sequencer.
// Holds the state encoding, the ACK/NACK bit values and the address match helper.
package i2c_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_GAP       = 3'd1,
        ST_ADDR      = 3'd2,
        ST_ADDR_ACK  = 3'd3,
        ST_DATA      = 3'd4,
        ST_DATA_ACK  = 3'd5,
        ST_WAIT_STOP = 3'd6
    } state_t;

    localparam logic       ACK        = 1'b0;
    localparam logic       NACK       = 1'b1;
    localparam logic [6:0] GCALL_ADDR = 7'h00;

    // Write-only addressing: the R/W bit must be 0 for the slave to respond.
    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] own,
                                        input logic       gcall_en);
        logic hit;
        hit = (addr_byte[7:1] == own) || (gcall_en && (addr_byte[7:1] == GCALL_ADDR));
        return hit && (addr_byte[0] == 1'b0);
    endfunction

endpackage

// File: rtl/i2c_rx_hold.sv
// One-entry valid/ready holding register for received bytes.
// The first-byte tag travels with its byte; a load wins over a same-cycle accept.
module i2c_rx_hold (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       load_first,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first
);

    logic [7:0] data_r;
    logic       valid_r;
    logic       first_r;

    // Holding register: load a new byte, or drop valid once accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r  <= 8'h00;
            valid_r <= 1'b0;
            first_r <= 1'b0;
        end else if (load) begin
            data_r  <= load_data;
            valid_r <= 1'b1;
            first_r <= load_first;
        end else if (valid_r && rx_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign rx_data  = data_r;
    assign rx_valid = valid_r;
    assign rx_first = first_r;

endmodule

// File: rtl/i2c_slave_rx_seq.sv
// Byte-level sequencer for the I2C slave receive path: address match, ACK/NACK
// generation and delivery of received bytes on a valid/ready stream.
module i2c_slave_rx_seq
    import i2c_pkg::*;
#(
    parameter bit GCALL_EN = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] own_addr,
    output logic       rd_en,
    output logic       is_byte,
    input  logic       rd_ld,
    input  logic       rd_data,
    input  logic       get_start,
    input  logic       get_stop,
    input  logic       bus_err,
    input  logic       rd_finish,
    output logic       wr_en,
    output logic       wr_bit,
    input  logic       wr_finish,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_first,
    output logic       addressed,
    output logic       err,
    output logic       overrun
);

    state_t     state_r;
    state_t     nxt_r;
    logic [7:0] sh_r;
    logic       first_flag_r;
    logic       ack_r;
    logic       addressed_r;
    logic       err_r;
    logic       overrun_r;

    logic       rd_phase_s;
    logic       wr_phase_s;
    logic       free_s;
    logic       load_s;

    // Phase enables and ACK bit decoded from the current state.
    always_comb begin
        rd_phase_s = 1'b0;
        wr_phase_s = 1'b0;
        wr_bit     = ACK;
        case (state_r)
            ST_IDLE, ST_ADDR, ST_DATA, ST_WAIT_STOP: rd_phase_s = 1'b1;
            ST_ADDR_ACK:                             wr_phase_s = 1'b1;
            ST_DATA_ACK: begin
                wr_phase_s = 1'b1;
                wr_bit     = ack_r;
            end
            default: begin
                rd_phase_s = 1'b0;
                wr_phase_s = 1'b0;
            end
        endcase
    end

    // A byte is loaded only when rd_finish wins the event priority in DATA.
    always_comb begin
        free_s = !rx_valid || rx_ready;
        if (en && (state_r == ST_DATA) && rd_finish && !bus_err && !get_start && !get_stop) begin
            load_s = free_s;
        end else begin
            load_s = 1'b0;
        end
    end

    // Sequencer FSM, shift register and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            nxt_r        <= ST_IDLE;
            sh_r         <= 8'h00;
            first_flag_r <= 1'b0;
            ack_r        <= ACK;
            addressed_r  <= 1'b0;
            err_r        <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            err_r     <= 1'b0;
            overrun_r <= 1'b0;
            if (!en) begin
                state_r     <= ST_IDLE;
                addressed_r <= 1'b0;
            end else begin
                if (((state_r == ST_ADDR) || (state_r == ST_DATA)) && rd_ld) begin
                    sh_r <= {sh_r[6:0], rd_data};
                end
                case (state_r)
                    ST_IDLE: begin
                        if (get_start) begin
                            state_r <= ST_GAP;
                            nxt_r   <= ST_ADDR;
                        end else if (rd_finish) begin
                            state_r <= ST_GAP;
                            nxt_r   <= ST_IDLE;
                        end
                    end
                    ST_GAP: state_r <= nxt_r;
                    ST_ADDR, ST_DATA: begin
                        if (bus_err) begin
                            err_r       <= 1'b1;
                            state_r     <= ST_IDLE;
                            addressed_r <= 1'b0;
                        end else if (get_start) begin
                            state_r     <= ST_GAP;
                            nxt_r       <= ST_ADDR;
                            addressed_r <= 1'b0;
                        end else if (get_stop) begin
                            state_r     <= ST_IDLE;
                            addressed_r <= 1'b0;
                        end else if (rd_finish) begin
                            state_r <= ST_GAP;
                            if (state_r == ST_ADDR) begin
                                nxt_r <= addr_match(sh_r, own_addr, GCALL_EN) ? ST_ADDR_ACK : ST_WAIT_STOP;
                            end else begin
                                nxt_r <= ST_DATA_ACK;
                                if (free_s) begin
                                    first_flag_r <= 1'b0;
                                    ack_r        <= ACK;
                                end else begin
                                    overrun_r <= 1'b1;
                                    ack_r     <= NACK;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (wr_finish) begin
                            addressed_r  <= 1'b1;
                            first_flag_r <= 1'b1;
                            state_r      <= ST_GAP;
                            nxt_r        <= ST_DATA;
                        end
                    end
                    ST_DATA_ACK: begin
                        if (wr_finish) begin
                            state_r <= ST_GAP;
                            nxt_r   <= (ack_r == ACK) ? ST_DATA : ST_WAIT_STOP;
                        end
                    end
                    ST_WAIT_STOP: begin
                        // A NACKed frame is left alone until the bus frees up.
                        if (get_start) begin
                            state_r     <= ST_GAP;
                            nxt_r       <= ST_ADDR;
                            addressed_r <= 1'b0;
                        end else if (get_stop) begin
                            state_r     <= ST_IDLE;
                            addressed_r <= 1'b0;
                        end else if (rd_finish) begin
                            state_r <= ST_GAP;
                            nxt_r   <= ST_WAIT_STOP;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        nxt_r   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    i2c_rx_hold u_hold (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .load_data  (sh_r),
        .load_first (first_flag_r),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_first   (rx_first)
    );

    assign rd_en     = en && rd_phase_s;
    assign wr_en     = en && wr_phase_s;
    assign is_byte   = 1'b1;
    assign addressed = addressed_r;
    assign err       = err_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_i2c_slave_rx_seq.sv
// Randomised bench for i2c_slave_rx_seq: an I2C master/reader/writer model drives
// frames while a frame-level model predicts ACKs, delivered bytes and pulses.
module tb_i2c_slave_rx_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [6:0] own_addr = 7'h50;
    logic       rd_ld = 1'b0, rd_data = 1'b0, get_start = 1'b0, get_stop = 1'b0;
    logic       bus_err = 1'b0, rd_finish = 1'b0, wr_finish = 1'b0, rx_ready = 1'b1;
    logic       rd_en, is_byte, wr_en, wr_bit, rx_valid, rx_first, addressed, err, overrun;
    logic [7:0] rx_data;
    logic       rd_en_g0, is_byte_g0, wr_en_g0, wr_bit_g0, rx_valid_g0, rx_first_g0;
    logic       addressed_g0, err_g0, overrun_g0;
    logic [7:0] rx_data_g0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    i2c_slave_rx_seq #(.GCALL_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .en(en), .own_addr(own_addr),
        .rd_en(rd_en), .is_byte(is_byte), .rd_ld(rd_ld), .rd_data(rd_data),
        .get_start(get_start), .get_stop(get_stop), .bus_err(bus_err), .rd_finish(rd_finish),
        .wr_en(wr_en), .wr_bit(wr_bit), .wr_finish(wr_finish),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_first(rx_first),
        .addressed(addressed), .err(err), .overrun(overrun)
    );

    i2c_slave_rx_seq #(.GCALL_EN(1'b0)) u_dut_g0 (
        .clk(clk), .rst(rst), .en(en), .own_addr(own_addr),
        .rd_en(rd_en_g0), .is_byte(is_byte_g0), .rd_ld(rd_ld), .rd_data(rd_data),
        .get_start(get_start), .get_stop(get_stop), .bus_err(bus_err), .rd_finish(rd_finish),
        .wr_en(wr_en_g0), .wr_bit(wr_bit_g0), .wr_finish(wr_finish),
        .rx_data(rx_data_g0), .rx_valid(rx_valid_g0), .rx_ready(rx_ready), .rx_first(rx_first_g0),
        .addressed(addressed_g0), .err(err_g0), .overrun(overrun_g0)
    );

    // Stream and pulse monitor, sampled mid-cycle.
    logic [8:0] got_q[$];
    int err_cnt = 0, ovr_cnt = 0, wr_cnt = 0, wr_g0_cnt = 0;
    always @(negedge clk) begin
        if (rx_valid && rx_ready) got_q.push_back({rx_first, rx_data});
        if (err) err_cnt++;
        if (overrun) ovr_cnt++;
        if (wr_en) wr_cnt++;
        if (wr_en_g0) wr_g0_cnt++;
    end

    // Frame-level reference model state.
    logic [8:0] exp_q[$];
    int got_rd = 0, exp_rd = 0;
    int err_base, ovr_base, wr_base;
    int m_ovr, m_err;
    bit m_match, m_first, m_nacked, m_held;
    logic [7:0] m_held_byte;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd_en(input string tag);
        int n = 0;
        while (!rd_en && n < 20) begin tick(); n++; end
        if (!rd_en) check_eq({tag, "_timeout"}, {31'd0, rd_en}, 32'd1);
    endtask

    task automatic send_bit(input logic b);
        rd_data = b;
        rd_ld = 1'b1;
        tick();
        rd_ld = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
    endtask

    // Master byte plus slave ACK slot; ack=1 when the slave drives nothing.
    task automatic send_byte(input logic [7:0] b, output logic ack);
        int n;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        rd_finish = 1'b1;
        tick();
        n = 0;
        while (rd_en && n < 10) begin tick(); n++; end
        if (rd_en) check_eq("rd_finish_timeout", {31'd0, rd_en}, 32'd0);
        rd_finish = 1'b0;
        n = 0;
        while (!wr_en && !rd_en && n < 10) begin tick(); n++; end
        if (wr_en) begin
            ack = wr_bit;
            repeat (2) tick();
            wr_finish = 1'b1;
            tick();
            n = 0;
            while (wr_en && n < 10) begin tick(); n++; end
            if (wr_en) check_eq("wr_finish_timeout", {31'd0, wr_en}, 32'd0);
            wr_finish = 1'b0;
            wait_rd_en("after_ack");
        end else begin
            ack = 1'b1;
            if (!rd_en) check_eq("slot_timeout", {31'd0, rd_en}, 32'd1);
        end
    endtask

    task automatic send_start();
        get_start = 1'b1;
        tick();
        get_start = 1'b0;
        wait_rd_en("start");
    endtask

    task automatic start_frame();
        err_base = err_cnt; ovr_base = ovr_cnt; wr_base = wr_cnt;
        m_ovr = 0; m_err = 0; m_held = 1'b0; m_nacked = 1'b1; m_match = 1'b0;
    endtask

    task automatic xfer_addr(input logic [7:0] a);
        logic ack;
        send_start();
        check_eq("addressed_after_start", {31'd0, addressed}, 32'd0);
        m_match = (a[0] == 1'b0) && (((a >> 1) == {1'b0, own_addr}) || ((a >> 1) == 8'd0));
        m_first = 1'b1;
        m_nacked = !m_match;
        send_byte(a, ack);
        check_eq("addr_ack", {31'd0, ack}, m_match ? 32'd0 : 32'd1);
        check_eq("addressed", {31'd0, addressed}, {31'd0, m_match});
    endtask

    task automatic xfer_data(input logic [7:0] b);
        logic ack;
        bit   free;
        if (m_nacked) return;
        free = rx_ready || !m_held;
        send_byte(b, ack);
        check_eq("data_ack", {31'd0, ack}, free ? 32'd0 : 32'd1);
        if (free) begin
            exp_q.push_back({m_first, b});
            m_first = 1'b0;
            if (!rx_ready) begin m_held = 1'b1; m_held_byte = b; end
        end else begin
            m_ovr++;
            m_nacked = 1'b1;
        end
    endtask

    task automatic end_frame();
        get_stop = 1'b1;
        tick();
        get_stop = 1'b0;
        tick();
        check_eq("addressed_after_stop", {31'd0, addressed}, 32'd0);
        check_eq("overrun_pulses", ovr_cnt - ovr_base, m_ovr);
        check_eq("err_pulses", err_cnt - err_base, m_err);
        if (!m_match) check_eq("no_wr_en", wr_cnt - wr_base, 32'd0);
        if (m_held) begin
            check_eq("held_valid", {31'd0, rx_valid}, 32'd1);
            check_eq("held_data", {24'd0, rx_data}, {24'd0, m_held_byte});
        end
        rx_ready = 1'b1;
        repeat (3) tick();
        check_eq("byte_count", got_q.size() - got_rd, exp_q.size() - exp_rd);
        while (exp_rd < exp_q.size() && got_rd < got_q.size()) begin
            check_eq("rx_byte", {23'd0, got_q[got_rd]}, {23'd0, exp_q[exp_rd]});
            got_rd++;
            exp_rd++;
        end
        got_rd = got_q.size();
        exp_rd = exp_q.size();
        m_held = 1'b0;
    endtask

    initial begin
        logic [7:0] a;
        int nb, wr_g0_base, n;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_eq("rst_rd_en", {31'd0, rd_en}, 32'd1);
        check_eq("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check_eq("rst_is_byte", {31'd0, is_byte}, 32'd1);
        check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check_eq("rst_flags", {28'd0, addressed, err, overrun, rx_first}, 32'd0);

        // Basic write of two bytes, then a non-matching address.
        rx_ready = 1'b1;
        start_frame(); xfer_addr(8'hA0); xfer_data(8'hA5); xfer_data(8'h3C); end_frame();
        start_frame(); xfer_addr(8'hA2); xfer_data(8'h55); end_frame();

        // Full holding register forces a NACK and an overrun pulse.
        rx_ready = 1'b0;
        start_frame(); xfer_addr(8'hA0); xfer_data(8'h11); xfer_data(8'h22); xfer_data(8'h33); end_frame();

        // Repeated start re-arms the first-byte tag.
        rx_ready = 1'b1;
        start_frame(); xfer_addr(8'hA0); xfer_data(8'h01); xfer_addr(8'hA0); xfer_data(8'h02); end_frame();

        // Misplaced stop mid-byte: bus_err wins over get_stop.
        start_frame(); xfer_addr(8'hA0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        bus_err = 1'b1; get_stop = 1'b1;
        tick();
        bus_err = 1'b0; get_stop = 1'b0;
        tick();
        check_eq("err_idle_rd_en", {31'd0, rd_en}, 32'd1);
        check_eq("err_addressed", {31'd0, addressed}, 32'd0);
        m_err = 1;
        end_frame();

        // General call is ACKed only by the instance that enables it.
        wr_g0_base = wr_g0_cnt;
        start_frame(); xfer_addr(8'h00); xfer_data(8'h5A); end_frame();
        check_eq("gcall_off_no_wr", wr_g0_cnt - wr_g0_base, 32'd0);

        // Dropping en releases everything and clears addressed.
        start_frame(); xfer_addr(8'hA0);
        en = 1'b0;
        tick();
        check_eq("en0_enables", {30'd0, rd_en, wr_en}, 32'd0);
        check_eq("en0_addressed", {31'd0, addressed}, 32'd0);
        en = 1'b1;
        tick();
        m_match = 1'b0; wr_base = wr_cnt;
        end_frame();

        // Reset while the data ACK is being driven.
        rx_ready = 1'b0;
        start_frame(); xfer_addr(8'hA0);
        for (int i = 7; i >= 0; i--) send_bit(i[0]);
        rd_finish = 1'b1;
        tick();
        n = 0;
        while (rd_en && n < 10) begin tick(); n++; end
        rd_finish = 1'b0;
        n = 0;
        while (!wr_en && n < 10) begin tick(); n++; end
        check_eq("pre_rst_wr_en", {31'd0, wr_en}, 32'd1);
        check_eq("pre_rst_valid", {31'd0, rx_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("post_rst_wr_en", {31'd0, wr_en}, 32'd0);
        check_eq("post_rst_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("post_rst_addressed", {31'd0, addressed}, 32'd0);
        check_eq("post_rst_rd_en", {31'd0, rd_en}, 32'd1);
        tick();
        rx_ready = 1'b1;
        repeat (2) tick();
        got_rd = got_q.size();

        // Randomised frames.
        for (int f = 0; f < 24; f++) begin
            own_addr = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 255));
            else a = {own_addr, 1'b0};
            nb = $urandom_range(1, 4);
            rx_ready = 1'($urandom_range(0, 1));
            start_frame();
            xfer_addr(a);
            for (int k = 0; k < nb; k++) xfer_data(8'($urandom_range(0, 255)));
            end_frame();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
